sccb_slave_responder: RTL
=========================

Name: sccb_slave_responder

Overview:
- SCCB target (slave) end of the camera control bus.
- Decodes 3-phase write, 2-phase write and 2-phase read transactions from an SCCB master, filtered by a device ID.
- Presents register writes and read requests on a simple parallel register port.
- Used as an on-chip OV7670 register model for closed-loop test of the SCCB master, and as a generic SCCB target.

Parameters:
- DEVICE_ID, 8'h42: write ID; bits [7:1] are compared, bit 0 of the received ID byte is R/W (1 = read).
- SYNC_STAGES, 2: synchronizer depth on i_sio_c, io_sio_d and i_sccb_e; minimum 2.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_sio_c  input  1  SCCB clock from the master.
- io_sio_d  inout  1  SCCB data line; the block only ever drives 0 or 1 when enabled, otherwise Z.
- i_sccb_e  input  1  SCCB enable, active low.
- o_wr_valid  output  1  one-cycle register write strobe.
- o_wr_addr  output  8  write sub-address.
- o_wr_data  output  8  write data.
- o_rd_valid  output  1  one-cycle strobe; i_rd_data sampled this cycle.
- o_rd_addr  output  8  current sub-address register, continuously driven.
- i_rd_data  input  8  read data; must be valid whenever o_rd_valid is high.
- o_busy  output  1  high from a matching ID byte until stop or abort.

Behaviour:
- Line conditioning:
  - i_sio_c, io_sio_d and i_sccb_e pass through SYNC_STAGES flops.
  - Rise/fall pulses are derived from the synchronized signals.
  - All protocol decisions use the synchronized signals only.
- Start: synchronized SIO_D falls while SIO_C high and SCCB_E low. Stop: SIO_D rises while SIO_C high.
- Sampling and driving:
  - Data bits are sampled on the SIO_C rise pulse, MSB first.
  - The block changes its driven SIO_D bit only on the SIO_C fall pulse.
- States:
  - IDLE -> ID on start.
  - ID: 8 bits. After the 8th bit:
    - ID[7:1] == DEVICE_ID[7:1]: go to ID_DC and latch the R/W bit; o_busy = 1.
    - Otherwise: go to WAIT_STOP.
  - ID_DC: 9th bit (don't-care). On its SIO_C fall: R/W = 0 -> SUB; R/W = 1 -> RD_DATA.
  - SUB: 8 bits, then SUB_DC. On SUB_DC completion, load the sub-address register (visible on o_rd_addr), then go to DATA.
  - DATA: 8 bits. On the 8th-bit rise: o_wr_addr = sub-address, o_wr_data = byte, o_wr_valid = 1 for exactly one cycle. Then DATA_DC -> WAIT_STOP.
  - RD_DATA:
    - On the SIO_C fall ending ID_DC: o_rd_valid pulses, i_rd_data is captured into the shift register, and bit 7 is driven.
    - Bits 6..0 are driven on the following falls.
    - On the fall after bit 0: release the line -> RD_NA.
  - RD_NA: NA bit sampled and ignored -> WAIT_STOP.
  - WAIT_STOP: line released; further bytes ignored until stop.
- A 2-phase write (stop in DATA before 8 bits) only updates the sub-address; no o_wr_valid.
- Stop in any state: return to IDLE, release the line, o_busy = 0. A partial byte is discarded; no write strobe.
- Repeated start in any non-IDLE state: restart at ID with bit count 0.
- SCCB_E high: immediate IDLE and line release. The sub-address register is kept.
- Reset values: o_wr_valid 0, o_rd_valid 0, o_wr_addr 8'h00, o_wr_data 8'h00, o_rd_addr 8'h00, o_busy 0, io_sio_d Z, state IDLE. Reset mid-transaction releases the line within the same reset assertion.
- Latency: strobes occur SYNC_STAGES+1 i_clk cycles after the corresponding physical SIO_C edge.
- Simultaneous start and stop in one cycle is impossible (same SIO_D edge); SIO_D edges while SIO_C is low are data changes only.

Optional Feature:
- Macro SCCB_SLAVE_ACK_EN.
- Defined: the block drives SIO_D low during ID_DC (matching ID only), SUB_DC and DATA_DC, I2C-ACK style. The drive is asserted on the fall before the 9th bit and released on the fall ending it.
- Undefined: the line is released (Z) during every don't-care bit.

Decomposition:
- Package sccb_pkg:
  - state enum (IDLE, ID, ID_DC, SUB, SUB_DC, DATA, DATA_DC, RD_DATA, RD_NA, WAIT_STOP);
  - SCCB_BYTE_W = 8;
  - SCCB_RW_BIT = 0;
  - default OV7670 ID 8'h42.
- Sub-module sccb_line_sync: synchronizers plus edge/start/stop detection. Outputs sio_c_rise, sio_c_fall, start, stop and the synchronized levels.

Test Plan:
- 3-phase write ID 0x42, sub 0x12, data 0x80 -> one o_wr_valid with o_wr_addr 0x12 and o_wr_data 0x80; o_busy falls after stop.
- 2-phase write ID 0x42, sub 0x0A, then 2-phase read ID 0x43 with i_rd_data = 0x76 -> o_rd_addr 0x0A, one o_rd_valid, bits 0,1,1,1,0,1,1,0 seen on SIO_D at SIO_C rises, no o_wr_valid.
- ID 0x60 write -> no strobes, o_busy 0, SIO_D never driven through stop.
- Stop after 5 data bits of a 3-phase write (sub 0x3A) -> no o_wr_valid; o_rd_addr = 0x3A; state IDLE.
- Repeated start after the sub byte, then a full 3-phase write 0x42/0x11/0x05 -> exactly one write with 0x11/0x05.
- Reset asserted during RD_DATA bit 3 -> SIO_D Z immediately, all outputs at reset values; next transaction decodes normally. With SCCB_SLAVE_ACK_EN, SIO_D reads 0 during each 9th bit of a matching write.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg -- shared types and constants for the SCCB target.
//
// Contents:
//   sccb_state_e    protocol state of the target FSM
//   SCCB_BYTE_W     bits per SCCB byte phase
//   SCCB_RW_BIT     position of the R/W flag inside the ID byte (1 = read)
//   SCCB_OV7670_ID  default write ID of the OV7670 sensor
//   sccb_id_match() compares an ID byte against a device ID, ignoring R/W
package sccb_pkg;

  localparam int         SCCB_BYTE_W    = 8;
  localparam int         SCCB_RW_BIT    = 0;
  localparam logic [7:0] SCCB_OV7670_ID = 8'h42;

  typedef enum logic [3:0] {
    IDLE,
    ID,
    ID_DC,
    SUB,
    SUB_DC,
    DATA,
    DATA_DC,
    RD_DATA,
    RD_NA,
    WAIT_STOP
  } sccb_state_e;

  // Every bit except the R/W flag has to agree.
  function automatic logic sccb_id_match(input logic [SCCB_BYTE_W-1:0] rx_id,
                                         input logic [SCCB_BYTE_W-1:0] dev_id);
    logic [SCCB_BYTE_W-1:0] care_mask;
    care_mask = ~(SCCB_BYTE_W'(1) << SCCB_RW_BIT);
    return ((rx_id ^ dev_id) & care_mask) == '0;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync -- conditions the raw SCCB lines for the target FSM.
//
// SIO_C, SIO_D and SCCB_E each pass through SYNC_STAGES flops (at least 2
// are always used). One more register of SIO_C/SIO_D gives edge pulses.
//
// Ports:
//   i_clk, i_reset_n  system clock / asynchronous active-low reset
//   i_sio_c           raw SCCB clock
//   i_sio_d           raw SCCB data (read back from the shared line)
//   i_sccb_e          raw SCCB enable, active low
//   sio_c_rise/fall   one-cycle pulses on synchronized SIO_C edges
//   start             SIO_D fell while SIO_C stayed high and SCCB_E is low
//   stop              SIO_D rose while SIO_C stayed high
//   sio_d_sync        synchronized SIO_D level (the sampled data bit)
//   sccb_e_sync       synchronized SCCB_E level
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sio_c,
  input  logic i_sio_d,
  input  logic i_sccb_e,
  output logic sio_c_rise,
  output logic sio_c_fall,
  output logic start,
  output logic stop,
  output logic sio_d_sync,
  output logic sccb_e_sync
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Bit order inside each stage: {sccb_e, sio_d, sio_c}.
  logic [2:0] line_raw;
  logic [2:0] stage_d   [NS];
  logic [2:0] sync_reg  [NS];
  logic [1:0] prev_reg;
  logic [2:0] line_cur;

  assign line_raw = {i_sccb_e, i_sio_d, i_sio_c};

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_d[gi] = line_raw;
      end else begin : g_chain
        assign stage_d[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Reset to the idle-bus levels so leaving reset creates no false start.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NS; i++) sync_reg[i] <= '1;
      prev_reg <= '1;
    end else begin
      for (int i = 0; i < NS; i++) sync_reg[i] <= stage_d[i];
      prev_reg <= line_cur[1:0];
    end
  end

  assign line_cur = sync_reg[NS-1];

  assign sio_c_rise  =  line_cur[0] & ~prev_reg[0];
  assign sio_c_fall  = ~line_cur[0] &  prev_reg[0];
  // SIO_C must be high both before and after the SIO_D edge, so a data
  // change racing a clock edge is never taken as a condition.
  assign start       = ~line_cur[1] &  prev_reg[1] & line_cur[0] & prev_reg[0] & ~line_cur[2];
  assign stop        =  line_cur[1] & ~prev_reg[1] & line_cur[0] & prev_reg[0];
  assign sio_d_sync  = line_cur[1];
  assign sccb_e_sync = line_cur[2];

endmodule

// File: rtl/sccb_slave_responder.sv
// sccb_slave_responder -- SCCB target with a parallel register port.
//
// Decodes 3-phase writes, 2-phase writes (sub-address only) and 2-phase
// reads addressed to DEVICE_ID. Writes appear as a one-cycle strobe on
// o_wr_*, reads request a byte via o_rd_valid / o_rd_addr / i_rd_data.
//
// Build option: define SCCB_SLAVE_ACK_EN to pull SIO_D low during the
// 9th bit of matching ID, sub-address and data phases (I2C-style ACK);
// otherwise the line stays released during every don't-care bit.
//
// Ports:
//   i_clk, i_reset_n  system clock / asynchronous active-low reset
//   i_sio_c, io_sio_d SCCB clock and bidirectional data (0, 1 or Z)
//   i_sccb_e          SCCB enable, active low
//   o_wr_valid/addr/data  one-cycle register write
//   o_rd_valid        one-cycle read request, i_rd_data captured then
//   o_rd_addr         current sub-address register
//   i_rd_data         read data for o_rd_addr
//   o_busy            high from a matching ID byte until stop or abort
module sccb_slave_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = SCCB_OV7670_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_sio_c,
  inout  wire                    io_sio_d,
  input  logic                   i_sccb_e,
  output logic                   o_wr_valid,
  output logic [SCCB_BYTE_W-1:0] o_wr_addr,
  output logic [SCCB_BYTE_W-1:0] o_wr_data,
  output logic                   o_rd_valid,
  output logic [SCCB_BYTE_W-1:0] o_rd_addr,
  input  logic [SCCB_BYTE_W-1:0] i_rd_data,
  output logic                   o_busy
);

  localparam int BW    = SCCB_BYTE_W;
  localparam int CNT_W = $clog2(BW);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BW - 1);

`ifdef SCCB_SLAVE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  logic sio_c_rise, sio_c_fall, start, stop, sio_d_sync, sccb_e_sync;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_sio_c     (i_sio_c),
    .i_sio_d     (io_sio_d),
    .i_sccb_e    (i_sccb_e),
    .sio_c_rise  (sio_c_rise),
    .sio_c_fall  (sio_c_fall),
    .start       (start),
    .stop        (stop),
    .sio_d_sync  (sio_d_sync),
    .sccb_e_sync (sccb_e_sync)
  );

  sccb_state_e      state_reg,    state_next;
  logic [CNT_W-1:0] bit_cnt_reg,  bit_cnt_next;
  logic [BW-1:0]    shift_reg,    shift_next;
  logic             rw_reg,       rw_next;
  logic [BW-1:0]    sub_addr_reg, sub_addr_next;
  logic             wr_valid_reg, wr_valid_next;
  logic [BW-1:0]    wr_addr_reg,  wr_addr_next;
  logic [BW-1:0]    wr_data_reg,  wr_data_next;
  logic             rd_valid_reg, rd_valid_next;
  logic             busy_reg,     busy_next;
  logic             sda_oe_reg,   sda_oe_next;
  logic             sda_out_reg,  sda_out_next;

  // Byte as it will look once the bit on the current rise is shifted in.
  logic [BW-1:0] rx_byte;
  assign rx_byte = {shift_reg[BW-2:0], sio_d_sync};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rw_reg       <= 1'b0;
      sub_addr_reg <= '0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      sda_oe_reg   <= 1'b0;
      sda_out_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rw_reg       <= rw_next;
      sub_addr_reg <= sub_addr_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      rd_valid_reg <= rd_valid_next;
      busy_reg     <= busy_next;
      sda_oe_reg   <= sda_oe_next;
      sda_out_reg  <= sda_out_next;
    end
  end

  // In the *_DC states bit_cnt is reused as "9th-bit rise seen": the fall
  // with it still 0 precedes the 9th bit, the fall with it set ends it.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rw_next       = rw_reg;
    sub_addr_next = sub_addr_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    rd_valid_next = 1'b0;
    busy_next     = busy_reg;
    sda_oe_next   = sda_oe_reg;
    sda_out_next  = sda_out_reg;

    if (sccb_e_sync || stop) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else if (start) begin
      state_next   = ID;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          sda_oe_next = 1'b0;
        end

        ID: begin
          if (sio_c_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next = '0;
              if (sccb_id_match(rx_byte, DEVICE_ID)) begin
                state_next = ID_DC;
                rw_next    = rx_byte[SCCB_RW_BIT];
                busy_next  = 1'b1;
              end else begin
                state_next = WAIT_STOP;
              end
            end
          end
        end

        ID_DC, SUB_DC, DATA_DC: begin
          if (sio_c_rise) begin
            bit_cnt_next = CNT_W'(1);
          end else if (sio_c_fall) begin
            if (bit_cnt_reg == '0) begin
              if (ACK_EN) begin
                sda_oe_next  = 1'b1;
                sda_out_next = 1'b0;
              end
            end else begin
              bit_cnt_next = '0;
              sda_oe_next  = 1'b0;
              if (state_reg == ID_DC) begin
                if (rw_reg) begin
                  state_next    = RD_DATA;
                  rd_valid_next = 1'b1;
                end else begin
                  state_next = SUB;
                end
              end else if (state_reg == SUB_DC) begin
                sub_addr_next = shift_reg;
                state_next    = DATA;
              end else begin
                state_next = WAIT_STOP;
              end
            end
          end
        end

        SUB: begin
          if (sio_c_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next = '0;
              state_next   = SUB_DC;
            end
          end
        end

        DATA: begin
          if (sio_c_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next  = '0;
              wr_addr_next  = sub_addr_reg;
              wr_data_next  = rx_byte;
              wr_valid_next = 1'b1;
              state_next    = DATA_DC;
            end
          end
        end

        RD_DATA: begin
          // The cycle o_rd_valid is high is the cycle i_rd_data is valid,
          // so the capture and the MSB drive happen one cycle after the fall.
          if (rd_valid_reg) begin
            shift_next   = i_rd_data;
            sda_oe_next  = 1'b1;
            sda_out_next = i_rd_data[BW-1];
            bit_cnt_next = '0;
          end else if (sio_c_fall) begin
            if (bit_cnt_reg == LAST_BIT) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              state_next   = RD_NA;
            end else begin
              sda_out_next = shift_reg[BW-2];
              shift_next   = {shift_reg[BW-2:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end

        RD_NA: begin
          if (sio_c_rise) state_next = WAIT_STOP;
        end

        WAIT_STOP: begin
          sda_oe_next = 1'b0;
        end

        default: begin
          state_next  = IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  assign io_sio_d   = sda_oe_reg ? sda_out_reg : 1'bz;
  assign o_wr_valid = wr_valid_reg;
  assign o_wr_addr  = wr_addr_reg;
  assign o_wr_data  = wr_data_reg;
  assign o_rd_valid = rd_valid_reg;
  assign o_rd_addr  = sub_addr_reg;
  assign o_busy     = busy_reg;

endmodule
